// File: rtl/popcount_frame_seq_pkg.sv
// Shared definitions for the popcount frame sequencer.
//   WORD_W          width of one counted word
//   CNT_W           width of the per-word ones count (0..63)
//   popseq_state_e  sequencer state encoding; the top also exposes it as a debug output
package popseq_pkg;

  localparam int WORD_W = 63;
  localparam int CNT_W  = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } popseq_state_e;

endpackage

// File: rtl/popcount_frame_seq_if.sv
// Word-in / result-out stream bundle for popcount_frame_seq.
//   in_valid/in_data/in_ready       word stream from the source
//   out_valid/out_ready             result stream to the consumer
//   out_total/out_words             result payload
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. A producer holding valid keeps its payload stable until the
// transfer; ready may be asserted independently of valid.
interface popcount_frame_seq_if #(
  parameter int LEN_W = 5,
  parameter int TOT_W = 10
) ();
  import popseq_pkg::*;

  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [TOT_W-1:0]  out_total;
  logic [LEN_W-1:0]  out_words;

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_total, out_words
  );

  // Source/consumer side.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_total, out_words
  );
endinterface

// File: rtl/popcount63_comb.sv
// Purely combinational ones counter for one 63-bit word.
//   data  in   WORD_W  word to count
//   ones  out  CNT_W   number of set bits (0..63)
module popcount63_comb
  import popseq_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  output logic [CNT_W-1:0]  ones
);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WORD_W; i++) begin
      ones = ones + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/popcount_frame_seq.sv
// Frame sequencer around a single combinational 63-bit ones counter.
// Accepts a frame of 1..MAX_WORDS words, accumulates their ones counts one
// word per cycle, and presents the frame total on a result stream.
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   start      in   frame request, sampled only in IDLE
//   len        in   requested words in frame (clamped to MAX_WORDS)
//   abort      in   drops the current frame while counting
//   busy       out  high whenever not IDLE
//   thresh     in   compare value for 'above'
//   above      out  registered out_total > thresh
//   state_dbg  out  current sequencer state
//   bus        slave side of popcount_frame_seq_if (word in, result out)
// Build option: define POPSEQ_THRESH_EN to enable the threshold compare;
// without it thresh is ignored and above is tied low.
module popcount_frame_seq
  import popseq_pkg::*;
#(
  parameter int MAX_WORDS = 16,
  parameter int LEN_W     = $clog2(MAX_WORDS + 1),
  parameter int TOT_W     = $clog2(63 * MAX_WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  input  logic                 abort,
  output logic                 busy,
  input  logic [TOT_W-1:0]     thresh,
  output logic                 above,
  output popseq_state_e        state_dbg,
  popcount_frame_seq_if.slave  bus
);

  popseq_state_e    state;
  logic [TOT_W-1:0] acc;
  logic [LEN_W-1:0] word_cnt;
  logic [LEN_W-1:0] len_q;
  logic [TOT_W-1:0] out_total_q;
  logic [LEN_W-1:0] out_words_q;
  logic             busy_q;
  logic             in_ready_q;
  logic             out_valid_q;

  logic [CNT_W-1:0] word_ones;
  logic [TOT_W-1:0] acc_next;
  logic [LEN_W-1:0] cnt_next;
  logic [LEN_W-1:0] len_clamped;
  logic             accept;

  popcount63_comb u_count (
    .data (bus.in_data),
    .ones (word_ones)
  );

  // in_ready_q is high exactly while in COUNT, so it doubles as the state gate.
  assign accept      = bus.in_valid & in_ready_q;
  assign acc_next    = acc + TOT_W'(word_ones);
  assign cnt_next    = word_cnt + LEN_W'(1);
  assign len_clamped = (len > LEN_W'(MAX_WORDS)) ? LEN_W'(MAX_WORDS) : len;

`ifdef POPSEQ_THRESH_EN
  logic [TOT_W-1:0] thresh_q;
  logic             above_q;
  assign above = above_q;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign above         = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      word_cnt    <= '0;
      len_q       <= '0;
      out_total_q <= '0;
      out_words_q <= '0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef POPSEQ_THRESH_EN
      thresh_q    <= '0;
      above_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len_clamped;
            acc      <= '0;
            word_cnt <= '0;
            busy_q   <= 1'b1;
`ifdef POPSEQ_THRESH_EN
            thresh_q <= thresh;
`endif
            if (len == '0) begin
              // Empty frame: report a zero result without entering COUNT.
              state       <= DONE;
              out_total_q <= '0;
              out_words_q <= '0;
              out_valid_q <= 1'b1;
`ifdef POPSEQ_THRESH_EN
              above_q     <= 1'b0;
`endif
            end else begin
              state      <= COUNT;
              in_ready_q <= 1'b1;
            end
          end
        end

        COUNT: begin
          if (abort) begin
            // Abort wins over a same-cycle word handshake; that word is dropped.
            state      <= IDLE;
            acc        <= '0;
            word_cnt   <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
          end else if (accept) begin
            acc      <= acc_next;
            word_cnt <= cnt_next;
            if (cnt_next == len_q) begin
              state       <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_total_q <= acc_next;
              out_words_q <= cnt_next;
`ifdef POPSEQ_THRESH_EN
              above_q     <= (acc_next > thresh_q);
`endif
            end
          end
        end

        DONE: begin
          // Result payload stays registered and untouched until accepted.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy          = busy_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_total = out_total_q;
  assign bus.out_words = out_words_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_popcount_frame_seq.sv
// Self-checking bench for popcount_frame_seq: a table of directed frames,
// hand-written abort/reset/stall sequences, then randomized frames checked
// against a frame-level model (sum of set bits over the first min(len,16) words).
module tb_popcount_frame_seq;
  import popseq_pkg::*;

  localparam int LEN_W = 5;
  localparam int TOT_W = 10;
  localparam int MAXW  = 16;
  localparam logic [62:0] ONES = {63{1'b1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic [TOT_W-1:0] thresh;
  logic             above;
  popseq_state_e    state_dbg;

  popcount_frame_seq_if #(.LEN_W(LEN_W), .TOT_W(TOT_W)) bus ();

  popcount_frame_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .thresh    (thresh),
    .above     (above),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [TOT_W-1:0] exp_q[$];
  logic [62:0]      word_q[$];

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [62:0]      w0, w1, w2, fill;
    int               n;
    logic [TOT_W-1:0] th;
    logic [TOT_W-1:0] exp_total;
    logic [LEN_W-1:0] exp_words;
    logic             exp_above;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic logic [62:0] rand_word();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    case ($urandom_range(0, 3))
      0:       return ONES;
      1:       return 63'd0;
      default: return r[62:0];
    endcase
  endfunction

  // With the threshold feature off, above must stay low regardless of totals.
  function automatic logic mask_above(input logic a);
`ifdef POPSEQ_THRESH_EN
    return a;
`else
    return 1'b0 & a;
`endif
  endfunction

  function automatic vec_t mk(input logic [LEN_W-1:0] l, input logic [62:0] w0, w1, w2, fill,
                              input int n, input logic [TOT_W-1:0] th, tot,
                              input logic [LEN_W-1:0] words, input logic ab);
    vec_t v;
    v.len = l; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.fill = fill; v.n = n;
    v.th = th; v.exp_total = tot; v.exp_words = words; v.exp_above = ab;
    return v;
  endfunction

  // Issue start, then push every word in word_q with random valid gaps.
  task automatic start_and_send(input logic [LEN_W-1:0] l, input logic [TOT_W-1:0] th);
    int budget;
    budget = 0;
    @(negedge clk);
    start = 1'b1; len = l; thresh = th;
    while (word_q.size() > 0 && budget < 400) begin
      @(negedge clk);
      start  = 1'b0;
      thresh = TOT_W'($urandom());
      budget++;
      if (bus.in_ready && $urandom_range(0, 3) != 0) begin
        bus.in_valid = 1'b1;
        bus.in_data  = word_q.pop_front();
      end else begin
        bus.in_valid = 1'b0;
        bus.in_data  = rand_word();
      end
    end
    if (word_q.size() != 0) check("words_left", word_q.size(), 0);
    word_q.delete();
  endtask

  task automatic run_frame(input logic [LEN_W-1:0] l, input logic [TOT_W-1:0] th,
                           input logic [TOT_W-1:0] exp_total, input logic [LEN_W-1:0] exp_words,
                           input logic exp_ab, input int hold, input bit poke);
    logic [TOT_W-1:0] exp_t;
    exp_q.push_back(exp_total);
    start_and_send(l, th);
    @(negedge clk);
    start = 1'b0; bus.in_valid = 1'b0; thresh = TOT_W'($urandom());
    exp_t = exp_q.pop_front();
    check("out_valid_latency", bus.out_valid, 1);
    check("out_total", bus.out_total, exp_t);
    check("out_words", bus.out_words, exp_words);
    check("done_in_ready", bus.in_ready, 0);
    check("done_busy", busy, 1);
    check("above", above, mask_above(exp_ab));
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      if (poke) begin
        start = 1'b1; len = 5'd3; abort = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = rand_word();
      end
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_total", bus.out_total, exp_t);
      check("hold_in_ready", bus.in_ready, 0);
    end
    start = 1'b0; abort = 1'b0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("after_accept_valid", bus.out_valid, 0);
    check("after_accept_busy", busy, 0);
  endtask

  task automatic run_abort(input logic [LEN_W-1:0] l, input int k);
    for (int i = 0; i < k; i++) word_q.push_back(rand_word());
    start_and_send(l, 10'd0);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b1; bus.in_valid = 1'b1; bus.in_data = ONES;
    @(negedge clk);
    abort = 1'b0; bus.in_valid = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) begin
      @(negedge clk);
      check("abort_no_result", bus.out_valid, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; thresh = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_total", bus.out_total, 0);
    check("rst_words", bus.out_words, 0);
    check("rst_above", above, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs[0] = mk(5'd3,  ONES,  63'd0, 63'd1, 63'd0, 3,  10'd10,   10'd64,   5'd3,  1'b1);
    vecs[1] = mk(5'd0,  63'd0, 63'd0, 63'd0, 63'd0, 0,  10'd0,    10'd0,    5'd0,  1'b0);
    vecs[2] = mk(5'd20, ONES,  ONES,  ONES,  ONES,  16, 10'd1008, 10'd1008, 5'd16, 1'b0);
    vecs[3] = mk(5'd1,  63'h7, 63'd0, 63'd0, 63'd0, 1,  10'd2,    10'd3,    5'd1,  1'b1);
    vecs[4] = mk(5'd1,  63'h3FF, 63'd0, 63'd0, 63'd0, 1, 10'd10,  10'd10,   5'd1,  1'b0);
    vecs[5] = mk(5'd1,  63'h7FF, 63'd0, 63'd0, 63'd0, 1, 10'd10,  10'd11,   5'd1,  1'b1);
    vecs[6] = mk(5'd16, 63'd1, 63'd1, 63'd1, 63'd1, 16, 10'd15,   10'd16,   5'd16, 1'b1);
    vecs[7] = mk(5'd2,  ONES,  ONES,  63'd0, 63'd0, 2,  10'd126,  10'd126,  5'd2,  1'b0);

    foreach (vecs[i]) begin
      for (int j = 0; j < vecs[i].n; j++)
        word_q.push_back(j == 0 ? vecs[i].w0 : j == 1 ? vecs[i].w1 : j == 2 ? vecs[i].w2 : vecs[i].fill);
      run_frame(vecs[i].len, vecs[i].th, vecs[i].exp_total, vecs[i].exp_words,
                vecs[i].exp_above, (i == 0) ? 5 : i % 3, (i == 0) || (i == 2));
    end

    // Abort mid-frame, then a short frame must not inherit the dropped words.
    run_abort(5'd4, 2);
    word_q.push_back(63'h7);
    run_frame(5'd1, 10'd0, 10'd3, 5'd1, 1'b1, 1, 1'b0);

    // Asynchronous reset while counting clears every output immediately.
    word_q.push_back(ONES); word_q.push_back(ONES);
    start_and_send(5'd4, 10'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_total", bus.out_total, 0);
    check("midrst_words", bus.out_words, 0);
    check("midrst_state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Randomized frames against the frame-level model.
    for (int r = 0; r < 40; r++) begin
      logic [LEN_W-1:0] l;
      logic [TOT_W-1:0] th, tot;
      int n;
      logic [62:0] w;
      l   = LEN_W'($urandom_range(0, 20));
      n   = (int'(l) > MAXW) ? MAXW : int'(l);
      th  = TOT_W'($urandom_range(0, 1008));
      if (n > 1 && $urandom_range(0, 5) == 0) begin
        run_abort(l, $urandom_range(0, n - 1));
      end else begin
        tot = '0;
        for (int j = 0; j < n; j++) begin
          w = rand_word();
          word_q.push_back(w);
          tot = tot + TOT_W'($countones(w));
        end
        run_frame(l, th, tot, LEN_W'(n), tot > th, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
